// File: rtl/prg_ray_slot_alloc.sv
// Ray-slot allocator: tags PRG rays with free ray IDs, recycles retired IDs.
// Keeps a pixelID per slot so retires can report which pixel finished.
package prg_pkg;
  typedef logic [15:0] pixelID_t;
  typedef struct packed {
    logic [31:0] origin;
    logic [31:0] dir;
    pixelID_t    pixelID;
  } prg_ray_t;
endpackage

module prg_ray_slot_alloc
  import prg_pkg::*;
#(
  parameter int NUM_SLOTS = 16,
  parameter int ID_W = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 prg_valid,
  input  prg_ray_t             prg_data,
  output logic                 prg_stall,
  output logic                 sh_valid,
  output prg_ray_t             sh_data,
  output logic [ID_W-1:0]      sh_rayID,
  input  logic                 sh_stall,
  input  logic                 ret_valid,
  input  logic [ID_W-1:0]      ret_rayID,
  output logic                 ret_pix_valid,
  output pixelID_t             ret_pixelID,
  output logic [ID_W:0]        num_free,
  output logic                 err
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [ID_W-1:0] LAST = ID_W'(NUM_SLOTS - 1);
  localparam logic [ID_W-1:0] INC  = ID_W'(1);
  localparam logic [ID_W:0]   ONE  = (ID_W+1)'(1);

  state_t               state;
  logic [ID_W-1:0]      init_cnt;
  logic [ID_W-1:0]      head;
  logic [ID_W-1:0]      tail;
  logic [NUM_SLOTS-1:0] in_use;
  logic [ID_W-1:0]      free_list [NUM_SLOTS];
  pixelID_t             pix_tab [NUM_SLOTS];

  logic            xfer;
  logic            ret_ok;
  logic            ret_bad;
  logic [ID_W-1:0] pop_id;

  assign pop_id    = free_list[head];
  assign prg_stall = (state != RUN) | (num_free == '0)
                   | (sh_valid & sh_stall);
  assign xfer      = prg_valid & ~prg_stall;
  assign ret_ok    = (state == RUN) & ret_valid & in_use[ret_rayID];
  assign ret_bad   = ret_valid & ~ret_ok;

  // Storage arrays: contents are rebuilt by INIT, so no reset needed.
  always_ff @(posedge clk) begin
    if (state == INIT)
      free_list[init_cnt] <= init_cnt;
    else if (ret_ok)
      free_list[tail] <= ret_rayID;
    if (xfer)
      pix_tab[pop_id] <= prg_data.pixelID;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= INIT;
      init_cnt      <= '0;
      head          <= '0;
      tail          <= '0;
      in_use        <= '0;
      num_free      <= '0;
      sh_valid      <= 1'b0;
      sh_data       <= '0;
      sh_rayID      <= '0;
      ret_pix_valid <= 1'b0;
      ret_pixelID   <= '0;
      err           <= 1'b0;
    end else begin
      err           <= err | ret_bad;
      ret_pix_valid <= ret_ok;
      unique case (state)
        INIT: begin
          init_cnt <= init_cnt + INC;
          num_free <= num_free + ONE;
          if (init_cnt == LAST)
            state <= RUN;
        end
        RUN: begin
          if (xfer) begin
            head           <= head + INC;
            in_use[pop_id] <= 1'b1;
          end
          if (ret_ok) begin
            tail              <= tail + INC;
            in_use[ret_rayID] <= 1'b0;
            ret_pixelID       <= pix_tab[ret_rayID];
          end
          unique case ({xfer, ret_ok})
            2'b10:   num_free <= num_free - ONE;
            2'b01:   num_free <= num_free + ONE;
            default: num_free <= num_free;
          endcase
        end
        default: state <= INIT;
      endcase
      if (xfer) begin
        sh_valid <= 1'b1;
        sh_data  <= prg_data;
        sh_rayID <= pop_id;
      end else if (sh_valid & ~sh_stall) begin
        sh_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prg_ray_slot_alloc.sv
// Directed bench for prg_ray_slot_alloc: init ramp, exhaust, retire,
// simultaneous pop/push, back-pressure and error flag.
module tb_prg_ray_slot_alloc;
  import prg_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       prg_valid;
  prg_ray_t   prg_data;
  logic       prg_stall;
  logic       sh_valid;
  prg_ray_t   sh_data;
  logic [3:0] sh_rayID;
  logic       sh_stall;
  logic       ret_valid;
  logic [3:0] ret_rayID;
  logic       ret_pix_valid;
  pixelID_t   ret_pixelID;
  logic [4:0] num_free;
  logic       err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prg_ray_slot_alloc #(.NUM_SLOTS(16)) dut (
    .clk(clk), .rst(rst),
    .prg_valid(prg_valid), .prg_data(prg_data), .prg_stall(prg_stall),
    .sh_valid(sh_valid), .sh_data(sh_data), .sh_rayID(sh_rayID),
    .sh_stall(sh_stall), .ret_valid(ret_valid), .ret_rayID(ret_rayID),
    .ret_pix_valid(ret_pix_valid), .ret_pixelID(ret_pixelID),
    .num_free(num_free), .err(err)
  );

  function automatic prg_ray_t mk(input pixelID_t p);
    prg_ray_t r;
    r.origin  = {16'hA000, p};
    r.dir     = {16'hD000, ~p};
    r.pixelID = p;
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset_init();
    rst = 1'b0; prg_valid = 1'b0; prg_data = '0;
    sh_stall = 1'b0; ret_valid = 1'b0; ret_rayID = '0;
    tick(); tick();
    rst = 1'b1;
    repeat (16) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; prg_valid = 1'b0; prg_data = '0;
    sh_stall = 1'b0; ret_valid = 1'b0; ret_rayID = '0;
    tick(); tick();
    checks++; if (prg_stall !== 1'b1) begin errors++; $display("FAIL rst_prg_stall got %b exp 1", prg_stall); end
    checks++; if (sh_valid !== 1'b0) begin errors++; $display("FAIL rst_sh_valid got %b exp 0", sh_valid); end
    checks++; if (sh_data !== '0) begin errors++; $display("FAIL rst_sh_data got %h exp 0", sh_data); end
    checks++; if (sh_rayID !== 4'd0) begin errors++; $display("FAIL rst_sh_rayID got %0d exp 0", sh_rayID); end
    checks++; if (ret_pix_valid !== 1'b0) begin errors++; $display("FAIL rst_ret_pix_valid got %b exp 0", ret_pix_valid); end
    checks++; if (ret_pixelID !== 16'h0) begin errors++; $display("FAIL rst_ret_pixelID got %h exp 0", ret_pixelID); end
    checks++; if (num_free !== 5'd0) begin errors++; $display("FAIL rst_num_free got %0d exp 0", num_free); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err); end
    rst = 1'b1;
    prg_valid = 1'b1;
    prg_data = mk(16'h0100);
    for (int k = 0; k < 16; k++) begin
      checks++; if (prg_stall !== 1'b1) begin errors++; $display("FAIL init_stall[%0d] got %b exp 1", k, prg_stall); end
      checks++; if (num_free !== 5'(k)) begin errors++; $display("FAIL init_num_free[%0d] got %0d exp %0d", k, num_free, k); end
      tick();
    end
    checks++; if (prg_stall !== 1'b0) begin errors++; $display("FAIL run_stall got %b exp 0", prg_stall); end
    checks++; if (num_free !== 5'd16) begin errors++; $display("FAIL run_num_free got %0d exp 16", num_free); end
    tick();
    prg_valid = 1'b0;
    checks++; if (sh_valid !== 1'b1) begin errors++; $display("FAIL first_sh_valid got %b exp 1", sh_valid); end
    checks++; if (sh_rayID !== 4'd0) begin errors++; $display("FAIL first_rayID got %0d exp 0", sh_rayID); end
    checks++; if (sh_data !== mk(16'h0100)) begin errors++; $display("FAIL first_sh_data got %h exp %h", sh_data, mk(16'h0100)); end
  endtask

  task automatic test_exhaust();
    pixelID_t p;
    do_reset_init();
    prg_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      p = (i == 5) ? 16'h0025 : pixelID_t'(16'h0200 + i);
      prg_data = mk(p);
      tick();
      checks++; if (sh_valid !== 1'b1) begin errors++; $display("FAIL exh_sh_valid[%0d] got %b exp 1", i, sh_valid); end
      checks++; if (sh_rayID !== 4'(i)) begin errors++; $display("FAIL exh_rayID[%0d] got %0d exp %0d", i, sh_rayID, i); end
      checks++; if (sh_data !== mk(p)) begin errors++; $display("FAIL exh_sh_data[%0d] got %h exp %h", i, sh_data, mk(p)); end
      checks++; if (num_free !== 5'(15 - i)) begin errors++; $display("FAIL exh_num_free[%0d] got %0d exp %0d", i, num_free, 15 - i); end
    end
    checks++; if (prg_stall !== 1'b1) begin errors++; $display("FAIL exh_stall got %b exp 1", prg_stall); end
    tick();
    prg_valid = 1'b0;
    checks++; if (sh_valid !== 1'b0) begin errors++; $display("FAIL exh_no_xfer got %b exp 0", sh_valid); end
    checks++; if (num_free !== 5'd0) begin errors++; $display("FAIL exh_empty got %0d exp 0", num_free); end
  endtask

  task automatic test_retire();
    ret_valid = 1'b1;
    ret_rayID = 4'd5;
    tick();
    ret_valid = 1'b0;
    checks++; if (ret_pix_valid !== 1'b1) begin errors++; $display("FAIL ret_pix_valid got %b exp 1", ret_pix_valid); end
    checks++; if (ret_pixelID !== 16'h0025) begin errors++; $display("FAIL ret_pixelID got %h exp 0025", ret_pixelID); end
    checks++; if (num_free !== 5'd1) begin errors++; $display("FAIL ret_num_free got %0d exp 1", num_free); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ret_err got %b exp 0", err); end
    tick();
    checks++; if (ret_pix_valid !== 1'b0) begin errors++; $display("FAIL ret_pulse got %b exp 0", ret_pix_valid); end
    prg_valid = 1'b1;
    prg_data = mk(16'h0055);
    tick();
    prg_valid = 1'b0;
    checks++; if (sh_rayID !== 4'd5) begin errors++; $display("FAIL realloc_rayID got %0d exp 5", sh_rayID); end
    checks++; if (sh_data !== mk(16'h0055)) begin errors++; $display("FAIL realloc_data got %h exp %h", sh_data, mk(16'h0055)); end
    checks++; if (num_free !== 5'd0) begin errors++; $display("FAIL realloc_num_free got %0d exp 0", num_free); end
  endtask

  task automatic test_simultaneous();
    ret_valid = 1'b1;
    ret_rayID = 4'd9;
    prg_valid = 1'b1;
    prg_data = mk(16'h0099);
    #1;
    checks++; if (prg_stall !== 1'b1) begin errors++; $display("FAIL sim_stall got %b exp 1", prg_stall); end
    tick();
    ret_valid = 1'b0;
    checks++; if (sh_valid !== 1'b0) begin errors++; $display("FAIL sim_no_xfer got %b exp 0", sh_valid); end
    checks++; if (ret_pixelID !== 16'h0209) begin errors++; $display("FAIL sim_ret_pixelID got %h exp 0209", ret_pixelID); end
    checks++; if (num_free !== 5'd1) begin errors++; $display("FAIL sim_num_free got %0d exp 1", num_free); end
    tick();
    prg_valid = 1'b0;
    checks++; if (sh_valid !== 1'b1) begin errors++; $display("FAIL sim_sh_valid got %b exp 1", sh_valid); end
    checks++; if (sh_rayID !== 4'd9) begin errors++; $display("FAIL sim_rayID got %0d exp 9", sh_rayID); end
    checks++; if (sh_data !== mk(16'h0099)) begin errors++; $display("FAIL sim_data got %h exp %h", sh_data, mk(16'h0099)); end
    checks++; if (num_free !== 5'd0) begin errors++; $display("FAIL sim_num_free2 got %0d exp 0", num_free); end
  endtask

  task automatic test_back_to_back();
    do_reset_init();
    prg_valid = 1'b1;
    prg_data = mk(16'h0040);
    tick();
    checks++; if (sh_rayID !== 4'd0 || sh_valid !== 1'b1) begin errors++; $display("FAIL bp_first got v=%b id=%0d exp v=1 id=0", sh_valid, sh_rayID); end
    sh_stall = 1'b1;
    prg_data = mk(16'h0041);
    #1;
    checks++; if (prg_stall !== 1'b1) begin errors++; $display("FAIL bp_stall got %b exp 1", prg_stall); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (sh_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d] got %b exp 1", i, sh_valid); end
      checks++; if (sh_rayID !== 4'd0) begin errors++; $display("FAIL bp_hold_id[%0d] got %0d exp 0", i, sh_rayID); end
      checks++; if (sh_data !== mk(16'h0040)) begin errors++; $display("FAIL bp_hold_data[%0d] got %h exp %h", i, sh_data, mk(16'h0040)); end
      checks++; if (num_free !== 5'd15) begin errors++; $display("FAIL bp_hold_free[%0d] got %0d exp 15", i, num_free); end
    end
    sh_stall = 1'b0;
    #1;
    checks++; if (prg_stall !== 1'b0) begin errors++; $display("FAIL bp_release got %b exp 0", prg_stall); end
    tick();
    checks++; if (sh_rayID !== 4'd1) begin errors++; $display("FAIL bp_next_id got %0d exp 1", sh_rayID); end
    checks++; if (sh_data !== mk(16'h0041)) begin errors++; $display("FAIL bp_next_data got %h exp %h", sh_data, mk(16'h0041)); end
    prg_data = mk(16'h0042);
    tick();
    prg_valid = 1'b0;
    checks++; if (sh_rayID !== 4'd2) begin errors++; $display("FAIL b2b_id got %0d exp 2", sh_rayID); end
    checks++; if (num_free !== 5'd13) begin errors++; $display("FAIL b2b_free got %0d exp 13", num_free); end
    tick();
    checks++; if (sh_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", sh_valid); end
  endtask

  task automatic test_bad_retire();
    do_reset_init();
    ret_valid = 1'b1;
    ret_rayID = 4'd3;
    tick();
    ret_valid = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_err got %b exp 1", err); end
    checks++; if (num_free !== 5'd16) begin errors++; $display("FAIL bad_num_free got %0d exp 16", num_free); end
    checks++; if (ret_pix_valid !== 1'b0) begin errors++; $display("FAIL bad_pix_valid got %b exp 0", ret_pix_valid); end
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_sticky got %b exp 1", err); end
    rst = 1'b0;
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL bad_rst_clear got %b exp 0", err); end
    tick();
    rst = 1'b1;
    ret_valid = 1'b1;
    ret_rayID = 4'd0;
    tick();
    ret_valid = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL init_ret_err got %b exp 1", err); end
    checks++; if (num_free !== 5'd1) begin errors++; $display("FAIL init_ret_free got %0d exp 1", num_free); end
  endtask

  initial begin
    test_reset();
    test_exhaust();
    test_retire();
    test_simultaneous();
    test_back_to_back();
    test_bad_retire();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
